tick_timer_sched: RTL and testbench

Shared time-base and timer scheduler. Divides `inclk` into single-cycle millisecond and second tick enables and shares them among `NCH` one-shot timer channels. Requesters load their channels through one round-robin-arbitrated load path. The block replaces free-running divided clocks with enables, so all downstream logic stays synchronous to `inclk`.

---
 rtl/tick_timer_sched.sv | 159 +++++++++++++++
 tb/tb_tick_timer_sched.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_timer_sched.sv
// tick_timer_sched: ms/s tick enables derived from inclk, shared by NCH down-counting timer channels
// loaded through one round-robin load path. Define TICK_SCHED_PERIODIC_EN to build auto-reload channels.
module tick_timer_sched #(
    parameter int CLK_PER_MS = 100000,
    parameter int MS_PER_S   = 1000,
    parameter int NCH        = 4,
    parameter int CNT_W      = 16
) (
    input  logic                 inclk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [NCH-1:0]       req,
    input  logic [NCH*CNT_W-1:0] req_val,
    input  logic [NCH-1:0]       req_base,
    input  logic [NCH-1:0]       req_periodic,
    input  logic [NCH-1:0]       stop,
    output logic [NCH-1:0]       ack,
    output logic [NCH-1:0]       busy,
    output logic [NCH-1:0]       expire,
    output logic                 ms_tick,
    output logic                 s_tick
);
    localparam int MS_W  = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam int S_W   = (MS_PER_S > 1) ? $clog2(MS_PER_S) : 1;
    localparam int IDX_W = $clog2(NCH);
    localparam logic [MS_W-1:0]  MS_LAST  = MS_W'(CLK_PER_MS - 1);
    localparam logic [S_W-1:0]   S_LAST   = S_W'(MS_PER_S - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCH - 1);

    logic [MS_W-1:0]  ms_cnt;
    logic [S_W-1:0]   s_cnt;
    logic             ms_wrap;
    logic [NCH-1:0]   elig;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W-1:0] cand;
    logic             gnt_vld;
    logic [NCH-1:0]   gnt_oh;

    assign ms_wrap = enable && (ms_cnt == MS_LAST);

    always_ff @(posedge inclk or posedge rst) begin
        if (rst) begin
            ms_cnt  <= '0;
            s_cnt   <= '0;
            ms_tick <= 1'b0;
            s_tick  <= 1'b0;
        end else begin
            ms_tick <= ms_wrap;
            s_tick  <= ms_wrap && (s_cnt == S_LAST);
            if (enable) begin
                ms_cnt <= ms_wrap ? '0 : ms_cnt + 1'b1;
            end
            if (ms_wrap) begin
                s_cnt <= (s_cnt == S_LAST) ? '0 : s_cnt + 1'b1;
            end
        end
    end

    // A channel whose ack is showing is not eligible, so a held req is only seen again one cycle later.
    assign elig = req & ~ack;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        gnt_oh  = '0;
        cand    = '0;
        for (int k = 0; k < NCH; k++) begin
            cand = (int'(ptr) + k >= NCH) ? IDX_W'(int'(ptr) + k - NCH) : IDX_W'(int'(ptr) + k);
            if (!gnt_vld && elig[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
        if (gnt_vld) begin
            gnt_oh[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge inclk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
            ack <= '0;
        end else begin
            ack <= gnt_oh;
            if (gnt_vld) begin
                ptr <= (gnt_idx == IDX_LAST) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

`ifndef TICK_SCHED_PERIODIC_EN
    logic unused_periodic;
    assign unused_periodic = ^req_periodic;
`endif

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] load_val;
        logic             base;
        logic             busy_q;
        logic             expire_q;
        logic             tick;
`ifdef TICK_SCHED_PERIODIC_EN
        logic             periodic;
        logic [CNT_W-1:0] reload;
`endif

        // A zero load is treated as one so it still expires on the first base tick.
        assign load_val = (req_val[i*CNT_W +: CNT_W] == '0) ? CNT_W'(1) : req_val[i*CNT_W +: CNT_W];
        assign tick     = busy_q && (base ? s_tick : ms_tick);
        assign busy[i]   = busy_q;
        assign expire[i] = expire_q;

        always_ff @(posedge inclk or posedge rst) begin
            if (rst) begin
                cnt      <= '0;
                base     <= 1'b0;
                busy_q   <= 1'b0;
                expire_q <= 1'b0;
`ifdef TICK_SCHED_PERIODIC_EN
                periodic <= 1'b0;
                reload   <= '0;
`endif
            end else begin
                expire_q <= 1'b0;
                if (stop[i]) begin
                    cnt    <= '0;
                    busy_q <= 1'b0;
                end else if (gnt_oh[i]) begin
                    cnt    <= load_val;
                    base   <= req_base[i];
                    busy_q <= 1'b1;
`ifdef TICK_SCHED_PERIODIC_EN
                    periodic <= req_periodic[i];
                    reload   <= load_val;
`endif
                end else if (tick) begin
                    if (cnt == CNT_W'(1)) begin
                        expire_q <= 1'b1;
`ifdef TICK_SCHED_PERIODIC_EN
                        if (periodic) begin
                            cnt <= reload;
                        end else begin
                            cnt    <= '0;
                            busy_q <= 1'b0;
                        end
`else
                        cnt    <= '0;
                        busy_q <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_tick_timer_sched.sv
// tb_tick_timer_sched: directed and random stimulus against a behavioural model of tick_timer_sched
// (enabled-cycle arithmetic for ticks, integer countdowns for channels), checked every cycle.
module tb_tick_timer_sched;
    localparam int NC = 4;
    localparam int CW = 8;

    logic           inclk = 1'b0;
    logic           rst;
    logic           enable;
    logic [NC-1:0]  req;
    logic [NC*CW-1:0] req_val;
    logic [NC-1:0]  req_base;
    logic [NC-1:0]  req_periodic;
    logic [NC-1:0]  stop;
    logic [NC-1:0]  ack;
    logic [NC-1:0]  busy;
    logic [NC-1:0]  expire;
    logic           ms_tick;
    logic           s_tick;

    tick_timer_sched #(.CLK_PER_MS(4), .MS_PER_S(3), .NCH(NC), .CNT_W(CW)) dut (
        .inclk(inclk), .rst(rst), .enable(enable), .req(req), .req_val(req_val),
        .req_base(req_base), .req_periodic(req_periodic), .stop(stop), .ack(ack),
        .busy(busy), .expire(expire), .ms_tick(ms_tick), .s_tick(s_tick)
    );

    always #5 inclk = ~inclk;

    int n_chk = 0;
    int n_bad = 0;

    // behavioural model state
    int            en_cnt;
    logic          m_ms, m_s;
    logic [NC-1:0] m_ack, m_busy, m_exp;
    int            m_ptr;
    int            rem [NC];
    int            mrel [NC];
    logic          mbase [NC];
    logic          mper [NC];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        en_cnt = 0; m_ms = 0; m_s = 0;
        m_ack = '0; m_busy = '0; m_exp = '0; m_ptr = 0;
        for (int i = 0; i < NC; i++) begin
            rem[i] = 0; mrel[i] = 0; mbase[i] = 0; mper[i] = 0;
        end
    endtask

    task automatic model_step();
        logic          t_ms, t_s;
        logic [NC-1:0] el;
        int            g, v;
        t_ms = m_ms;
        t_s  = m_s;
        el = req & ~m_ack;
        g = -1;
        for (int k = 0; k < NC; k++)
            if (g < 0 && el[(m_ptr + k) % NC]) g = (m_ptr + k) % NC;
        m_ack = '0;
        if (g >= 0) begin
            m_ack[g] = 1'b1;
            m_ptr = (g + 1) % NC;
        end
        m_exp = '0;
        for (int i = 0; i < NC; i++) begin
            v = int'(req_val[i*CW +: CW]);
            if (stop[i]) begin
                m_busy[i] = 1'b0; rem[i] = 0;
            end else if (g == i) begin
                rem[i] = (v == 0) ? 1 : v;
                mrel[i] = rem[i];
                mbase[i] = req_base[i];
`ifdef TICK_SCHED_PERIODIC_EN
                mper[i] = req_periodic[i];
`else
                mper[i] = 1'b0;
`endif
                m_busy[i] = 1'b1;
            end else if (m_busy[i] && (mbase[i] ? t_s : t_ms)) begin
                rem[i]--;
                if (rem[i] == 0) begin
                    m_exp[i] = 1'b1;
                    if (mper[i]) rem[i] = mrel[i];
                    else m_busy[i] = 1'b0;
                end
            end
        end
        if (enable) begin
            en_cnt++;
            m_ms = (en_cnt % 4 == 0);
            m_s  = (en_cnt % 12 == 0);
        end else begin
            m_ms = 1'b0;
            m_s  = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge inclk);
        #1;
        model_step();
        chk("ms_tick", 32'(ms_tick), 32'(m_ms));
        chk("s_tick", 32'(s_tick), 32'(m_s));
        chk("ack", 32'(ack), 32'(m_ack));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("expire", 32'(expire), 32'(m_exp));
        @(negedge inclk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_ack", 32'(ack), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_expire", 32'(expire), 0);
        chk("rst_ticks", {30'd0, ms_tick, s_tick}, 0);
        @(posedge inclk);
        @(negedge inclk);
        rst = 1'b0;
    endtask

    task automatic load(input int ch, input int val, input logic b, input logic per);
        int n;
        req_val[ch*CW +: CW] = CW'(val);
        req_base[ch] = b;
        req_periodic[ch] = per;
        req[ch] = 1'b1;
        step();
        n = 1;
        while (!m_ack[ch] && n < 10) begin
            step();
            n++;
        end
        chk("load_ack", 32'(ack[ch]), 1);
        req[ch] = 1'b0;
    endtask

    initial begin
        int n, m;
        rst = 1'b1; enable = 1'b0; req = '0; req_val = '0;
        req_base = '0; req_periodic = '0; stop = '0;
        model_reset();
        @(negedge inclk);
        enable = 1'b1;
        do_reset();

        // tick cadence, then a 5-cycle enable gap
        for (int c = 1; c <= 12; c++) begin
            step();
            if (c == 4) chk("ms_first", 32'(ms_tick), 1);
        end
        chk("s_first", {30'd0, ms_tick, s_tick}, 3);
        enable = 1'b0;
        repeat (5) step();
        enable = 1'b1;
        repeat (4) step();
        chk("ms_shift", 32'(ms_tick), 1);

        // one-shot on ch0
        req_val[0 +: CW] = 8'd3; req_base[0] = 1'b0; req[0] = 1'b1;
        step();
        chk("oneshot_ack", 32'(ack[0]), 1);
        req[0] = 1'b0;
        n = 0;
        repeat (20) begin
            step();
            if (expire[0]) n++;
        end
        chk("oneshot_cnt", n, 1);

        // contention from a fresh pointer, then a repeat after the pointer wraps
        do_reset();
        req_val = {4{8'd9}}; req_base = '0; req_periodic = '0;
        req = 4'hf;
        for (int k = 0; k < NC; k++) begin
            step();
            chk("cont_ack", 32'(ack), 32'(1 << k));
            req = req & ~m_ack;
        end
        stop = 4'hf; step(); stop = '0;
        req = 4'hf;
        for (int k = 0; k < NC; k++) begin
            step();
            chk("cont_rep", 32'(ack), 32'(1 << k));
            req = req & ~m_ack;
        end
        stop = 4'hf; step(); stop = '0;

        // stop and grant together on ch1
        req_val[1*CW +: CW] = 8'd2; req[1] = 1'b1; stop[1] = 1'b1;
        step();
        chk("stopld_ack", 32'(ack[1]), 1);
        chk("stopld_busy", 32'(busy[1]), 0);
        req[1] = 1'b0; stop[1] = 1'b0;
        n = 0;
        repeat (20) begin
            step();
            if (expire[1]) n++;
        end
        chk("stopld_noexp", n, 0);

        // s base with retrigger, then a zero load on ms base
        load(2, 2, 1'b1, 1'b0);
        n = 0;
        while (!m_s && n < 40) begin step(); n++; end
        chk("wait_s1", 32'(n < 40), 1);
        load(2, 1, 1'b1, 1'b0);
        n = 0;
        while (!m_s && n < 40) begin step(); n++; end
        chk("wait_s2", 32'(n < 40), 1);
        step();
        chk("s_retrig", 32'(expire[2]), 1);
        load(2, 0, 1'b0, 1'b0);
        n = 0;
        while (!m_ms && n < 10) begin step(); n++; end
        chk("wait_ms", 32'(n < 10), 1);
        step();
        chk("zero_load", 32'(expire[2]), 1);

        // periodic on ch3
        load(3, 2, 1'b0, 1'b1);
        n = 0; m = 0;
        repeat (40) begin
            step();
            if (expire[3]) n++;
            if (m_exp[3]) m++;
        end
        chk("per_cnt", n, m);
`ifdef TICK_SCHED_PERIODIC_EN
        chk("per_min", 32'(n >= 4), 1);
`else
        chk("per_once", n, 1);
`endif
        stop[3] = 1'b1; step(); stop[3] = 1'b0;
        n = 0;
        repeat (16) begin
            step();
            if (expire[3]) n++;
        end
        chk("per_stopped", n, 0);

        // random traffic with a reset in the middle
        for (int c = 0; c < 3000; c++) begin
            enable = ($urandom_range(0, 9) != 0);
            stop = '0;
            for (int i = 0; i < NC; i++) begin
                if (req[i] && m_ack[i]) begin
                    req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 5) == 0) begin
                    req[i] = 1'b1;
                    req_val[i*CW +: CW] = CW'($urandom_range(0, 5));
                    req_base[i] = ($urandom_range(0, 3) == 0);
                    req_periodic[i] = 1'($urandom_range(0, 1));
                end
                if ($urandom_range(0, 39) == 0) stop[i] = 1'b1;
            end
            if (c == 1500) do_reset();
            step();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog total=%0d bad=%0d", n_chk, n_bad);
        $fatal(1, "timeout");
    end
endmodule
